// File: rtl/rom_download_router_pkg.sv
// Shared types and the region decoder for the ROM download router.
package rom_download_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RG_CPU  = 2'd0,
        RG_SPR  = 2'd1,
        RG_NONE = 2'd2
    } region_t;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } fifo_entry_t;

    // Classify a download byte address; the limit is widened so base+size cannot wrap.
    function automatic region_t decode_region(input logic [24:0] addr,
                                              input logic [24:0] base,
                                              input logic [24:0] size);
        logic [25:0] lim_v;
        lim_v = {1'b0, base} + {1'b0, size};
        if ({1'b0, addr} < {1'b0, base}) begin
            return RG_CPU;
        end else if ({1'b0, addr} < lim_v) begin
            return RG_SPR;
        end else begin
            return RG_NONE;
        end
    endfunction

endpackage

// File: rtl/rom_download_router_fifo.sv
// Small synchronous FIFO of download entries; head is the oldest entry (show-ahead).
module rom_download_fifo
    import rom_download_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  fifo_entry_t din,
    output logic        full,
    output logic        empty,
    output fifo_entry_t head
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    fifo_entry_t     mem_r [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_r;
    logic [AW:0]     rd_ptr_r;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; push and pop in the same cycle are independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/rom_download_router.sv
// ROM download router: ioctl byte stream -> buffered, region-decoded sdram toggle writes.
// Optional feature macro ROM_CHECKSUM_EN adds a 16-bit checksum of acknowledged bytes.
module rom_download_router
    import rom_download_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [24:0] SP_BASE    = 25'h11000,
    parameter logic [24:0] SP_SIZE    = 25'h20000,
    parameter logic [7:0]  ROM_INDEX  = 8'd0
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_downl,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [15:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port_we,
    output logic        rom_loaded,
`ifdef ROM_CHECKSUM_EN
    output logic [15:0] checksum,
`endif
    output logic        overflow
);
    state_t      state_r, state_s;
    region_t     sel_r, head_rg_s;
    fifo_entry_t din_s, head_s;
    logic        wr_r, downl_r, routed_r;
    logic        idx_match_s, push_req_s, push_s, start_s;
    logic        full_s, empty_s, pop_s, issue_cpu_s, issue_spr_s, ack_match_s;
    logic [16:0] offs_s;

    assign idx_match_s = (ioctl_index == ROM_INDEX);
    assign push_req_s  = ioctl_wr && !wr_r && ioctl_downl && idx_match_s;
    assign push_s      = push_req_s && !full_s;
    assign start_s     = ioctl_downl && !downl_r && idx_match_s;
    assign din_s       = '{addr: ioctl_addr, data: ioctl_dout};
    assign head_rg_s   = decode_region(head_s.addr, SP_BASE, SP_SIZE);
    // Only the low 17 offset bits reach the sprite bus, so subtract on those alone.
    assign offs_s      = head_s.addr[16:0] - SP_BASE[16:0];

    rom_download_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   (din_s),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    // Select the ack comparison for the port that owns the outstanding request.
    always_comb begin
        ack_match_s = 1'b0;
        if (sel_r == RG_SPR) begin
            ack_match_s = (port2_ack == port2_req);
        end else begin
            ack_match_s = (port1_ack == port1_req);
        end
    end

    // Next-state and one-cycle control strobes for the write sequencer.
    always_comb begin
        state_s     = state_r;
        pop_s       = 1'b0;
        issue_cpu_s = 1'b0;
        issue_spr_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!empty_s) begin
                    state_s = S_ISSUE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                case (head_rg_s)
                    RG_CPU: begin
                        issue_cpu_s = 1'b1;
                        state_s     = S_WAIT;
                    end
                    RG_SPR: begin
                        issue_spr_s = 1'b1;
                        state_s     = S_WAIT;
                    end
                    default: begin
                        pop_s   = 1'b1;
                        state_s = S_IDLE;
                    end
                endcase
            end
            S_WAIT: begin
                if (ack_match_s) begin
                    pop_s   = 1'b1;
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WAIT;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Strobe and download-enable history for edge detection.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_r    <= 1'b0;
            downl_r <= 1'b0;
        end else begin
            wr_r    <= ioctl_wr;
            downl_r <= ioctl_downl;
        end
    end

    // Port buses and toggle requests; while idle, req re-aligns to ack so no write is implied.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            port1_req <= 1'b0;
            port1_a   <= 23'd0;
            port1_ds  <= 2'b00;
            port1_d   <= 16'd0;
            port2_req <= 1'b0;
            port2_a   <= 16'd0;
            port2_ds  <= 2'b00;
            port2_d   <= 16'd0;
            sel_r     <= RG_CPU;
        end else begin
            if (state_r == S_IDLE) begin
                port1_req <= port1_ack;
                port2_req <= port2_ack;
            end
            if (issue_cpu_s) begin
                port1_req <= ~port1_req;
                port1_a   <= head_s.addr[23:1];
                port1_ds  <= {head_s.addr[0], ~head_s.addr[0]};
                port1_d   <= {head_s.data, head_s.data};
                sel_r     <= RG_CPU;
            end
            if (issue_spr_s) begin
                port2_req <= ~port2_req;
                port2_a   <= {offs_s[14:0], offs_s[16]};
                port2_ds  <= {offs_s[15], ~offs_s[15]};
                port2_d   <= {head_s.data, head_s.data};
                sel_r     <= RG_SPR;
            end
        end
    end

    // Download status: start clears the sticky flags, completion waits for the FIFO to drain.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            port_we    <= 1'b0;
            rom_loaded <= 1'b0;
            overflow   <= 1'b0;
            routed_r   <= 1'b0;
        end else begin
            port_we <= (ioctl_downl && idx_match_s) || !empty_s;
            if (start_s) begin
                rom_loaded <= 1'b0;
                routed_r   <= 1'b1;
            end else if (routed_r && !ioctl_downl && empty_s && (state_r == S_IDLE)) begin
                rom_loaded <= 1'b1;
                routed_r   <= 1'b0;
            end
            if (start_s) begin
                overflow <= 1'b0;
            end else if (push_req_s && full_s) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef ROM_CHECKSUM_EN
    // Running sum of bytes the sdram has acknowledged.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= 16'd0;
        end else if (start_s) begin
            checksum <= 16'd0;
        end else if (pop_s && (state_r == S_WAIT)) begin
            checksum <= checksum + {8'h00, head_s.data};
        end
    end
`endif

endmodule

// File: tb/tb_rom_download_router.sv
// Directed self-checking bench for rom_download_router (default parameters, FIFO_DEPTH=4).
module tb_rom_download_router;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_downl;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        port1_req, port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req, port2_ack;
    logic [15:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        port_we, rom_loaded, overflow;
`ifdef ROM_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int total = 0;
    int bad   = 0;
    logic ack_hold = 1'b0;
    logic [40:0] log1[$];
    logic [33:0] log2[$];

    rom_download_router dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_downl (ioctl_downl),
        .ioctl_index (ioctl_index),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .port1_req   (port1_req),
        .port1_ack   (port1_ack),
        .port1_a     (port1_a),
        .port1_ds    (port1_ds),
        .port1_d     (port1_d),
        .port2_req   (port2_req),
        .port2_ack   (port2_ack),
        .port2_a     (port2_a),
        .port2_ds    (port2_ds),
        .port2_d     (port2_d),
        .port_we     (port_we),
        .rom_loaded  (rom_loaded),
`ifdef ROM_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .overflow    (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // sdram model: ack follows req five cycles later unless held off
    initial begin
        int c1, c2;
        c1 = 0;
        c2 = 0;
        port1_ack = 1'b0;
        port2_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                port1_ack = 1'b0;
                port2_ack = 1'b0;
                c1 = 0;
                c2 = 0;
            end else begin
                if (!ack_hold && port1_req !== port1_ack) begin
                    c1++;
                    if (c1 >= 5) begin port1_ack = port1_req; c1 = 0; end
                end else c1 = 0;
                if (!ack_hold && port2_req !== port2_ack) begin
                    c2++;
                    if (c2 >= 5) begin port2_ack = port2_req; c2 = 0; end
                end else c2 = 0;
            end
        end
    end

    // write log: bus contents captured at every req toggle
    initial begin
        logic p1, p2;
        p1 = 1'b0;
        p2 = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (!reset_n) begin
                p1 = 1'b0;
                p2 = 1'b0;
            end else begin
                if (port1_req !== p1) begin log1.push_back({port1_a, port1_ds, port1_d}); p1 = port1_req; end
                if (port2_req !== p2) begin log2.push_back({port2_a, port2_ds, port2_d}); p2 = port2_req; end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic wait_log1(input int n, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (log1.size() >= n) break;
            @(negedge clk_sys);
        end
        chk(tag, 64'(log1.size() >= n), 64'd1);
    endtask

    task automatic wait_acked(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (port1_req === port1_ack && port2_req === port2_ack) break;
            @(negedge clk_sys);
        end
        chk(tag, {port1_req, port2_req}, {port1_ack, port2_ack});
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic wait_loaded(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (rom_loaded === 1'b1) break;
            @(negedge clk_sys);
        end
        chk(tag, 64'(rom_loaded), 64'd1);
    endtask

    initial begin
        logic [24:0] ea;
        logic [7:0]  ed;
        reset_n = 1'b0; ioctl_downl = 1'b0; ioctl_index = 8'd0;
        ioctl_wr = 1'b0; ioctl_addr = 25'd0; ioctl_dout = 8'd0;
        repeat (3) @(negedge clk_sys);
        chk("rst_p1_req", 64'(port1_req), 64'd0);
        chk("rst_p2_req", 64'(port2_req), 64'd0);
        chk("rst_buses", {port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d}, 64'd0);
        chk("rst_flags", {port_we, rom_loaded, overflow}, 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // 1: CPU byte, latency and bus contents
        ioctl_downl = 1'b1;
        @(negedge clk_sys);
        ioctl_addr = 25'h00003; ioctl_dout = 8'hA5; ioctl_wr = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        chk("t1_req_after_push", 64'(port1_req), 64'd0);
        chk("t1_port_we", 64'(port_we), 64'd1);
        @(negedge clk_sys);
        chk("t1_req_lat1", 64'(port1_req), 64'd0);
        @(negedge clk_sys);
        chk("t1_req_toggle", 64'(port1_req), 64'd1);
        chk("t1_bus", {port1_a, port1_ds, port1_d}, {23'h000001, 2'b10, 16'hA5A5});
        wait_acked("t1_acked");
        chk("t1_writes", 64'(log1.size()), 64'd1);

        // 2: sprite byte at offset 0x18002
        send_byte(25'h29002, 8'h3C);
        for (int i = 0; i < 20 && log2.size() < 1; i++) @(negedge clk_sys);
        chk("t2_p2_writes", 64'(log2.size()), 64'd1);
        if (log2.size() > 0) chk("t2_bus", log2[0], {16'h0005, 2'b10, 16'h3C3C});
        chk("t2_p1_unchanged", 64'(log1.size()), 64'd1);
        wait_acked("t2_acked");
        chk("t2_no_overflow", 64'(overflow), 64'd0);

        // 3: burst of 6 with ack held -> 4 stored, overflow
        ack_hold = 1'b1;
        for (int k = 0; k < 6; k++) send_byte(25'h10 + 25'(k), 8'h10 + 8'(k));
        chk("t3_overflow", 64'(overflow), 64'd1);
        ack_hold = 1'b0;
        wait_log1(5, "t3_reach5");
        wait_acked("t3_acked");
        repeat (10) @(negedge clk_sys);
        chk("t3_exact4", 64'(log1.size()), 64'd5);
        for (int k = 0; k < 4; k++) begin
            ea = 25'h10 + 25'(k);
            ed = 8'h10 + 8'(k);
            if (log1.size() > k + 1) chk("t3_order", log1[k+1], {ea[23:1], ea[0], ~ea[0], ed, ed});
        end

        // 4: drop downl with two writes pending
        ack_hold = 1'b1;
        send_byte(25'h20, 8'h01);
        send_byte(25'h21, 8'h02);
        ioctl_downl = 1'b0;
        repeat (5) @(negedge clk_sys);
        chk("t4_not_loaded_held", 64'(rom_loaded), 64'd0);
        ack_hold = 1'b0;
        wait_log1(7, "t4_second_req");
        chk("t4_not_loaded_pending", 64'(rom_loaded), 64'd0);
        wait_loaded("t4_loaded");
        chk("t4_acked", 64'(port1_req), 64'(port1_ack));
        if (log1.size() > 6) chk("t4_w2", log1[6], {23'h10, 2'b10, 16'h0202});

        // 5: out-of-range byte is discarded quickly
        ioctl_downl = 1'b1;
        @(negedge clk_sys);
        chk("t5_start_clears", {rom_loaded, overflow}, 64'd0);
        send_byte(25'h31000, 8'h77);
        ioctl_downl = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("t5_loaded_fast", 64'(rom_loaded), 64'd1);
        chk("t5_no_writes", {32'(log1.size()), 32'(log2.size())}, {32'd7, 32'd1});

        // 6: reset during S_WAIT, then a fresh download
        ioctl_downl = 1'b1;
        @(negedge clk_sys);
        ack_hold = 1'b1;
        send_byte(25'h40, 8'h55);
        repeat (3) @(negedge clk_sys);
        chk("t6_in_wait", 64'(log1.size()), 64'd8);
        reset_n = 1'b0;
        ioctl_downl = 1'b0;
        #1;
        chk("t6_rst_reqs", {port1_req, port2_req}, 64'd0);
        chk("t6_rst_buses", {port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d}, 64'd0);
        chk("t6_rst_flags", {port_we, rom_loaded, overflow}, 64'd0);
        ack_hold = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        chk("t6_fifo_empty", 64'(port_we), 64'd0);
        chk("t6_no_stale_write", 64'(log1.size()), 64'd8);
        ioctl_downl = 1'b1;
        @(negedge clk_sys);
        send_byte(25'h50, 8'hFF);
        send_byte(25'h51, 8'h02);
        wait_log1(10, "t6_new_writes");
        wait_acked("t6_acked");
        ioctl_downl = 1'b0;
        wait_loaded("t6_loaded");
        if (log1.size() > 9) begin
            chk("t6_w0", log1[8], {23'h28, 2'b01, 16'hFFFF});
            chk("t6_w1", log1[9], {23'h28, 2'b10, 16'h0202});
        end
`ifdef ROM_CHECKSUM_EN
        chk("t6_checksum", 64'(checksum), 64'h0101);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
